// File: rtl/sr_input_conditioner.sv
// Input conditioner for the sr_latch: synchronise, debounce and edge-detect two raw
// request lines, then arbitrate them into mutually exclusive fixed-width S/R pulses.
module sr_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 2,
    parameter int GAP_CYCLES      = 1,
    parameter bit RESET_PRIORITY  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic reset_raw,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic state_q
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MAXC = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE_S,
        PULSE_R,
        GAP
    } state_t;

    // Channel index 0 is set, 1 is reset throughout.
    logic [SYNC_STAGES-1:0] set_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic [1:0]             synced;
    logic [1:0][DW-1:0]     cnt;
    logic [1:0]             lvl;
    logic [1:0]             lvl_d;
    logic [1:0]             rise;
    logic [1:0]             pend;
    state_t                 st;
    logic [CW-1:0]          fcnt;

    assign synced = {rst_sync[SYNC_STAGES-1], set_sync[SYNC_STAGES-1]};
    assign rise   = lvl & ~lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_sync <= '0;
            rst_sync <= '0;
        end else begin
            set_sync <= {set_sync[SYNC_STAGES-2:0], set_raw};
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], reset_raw};
        end
    end

    // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            lvl   <= '0;
            lvl_d <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (synced[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (int'(cnt[i]) == DEBOUNCE_CYCLES - 1) begin
                    lvl[i] <= synced[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            lvl_d <= lvl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            fcnt     <= '0;
            pend     <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            state_q  <= 1'b0;
        end else begin
            conflict <= 1'b0;
            pend     <= pend | rise;
            unique case (st)
                IDLE: begin
                    fcnt <= '0;
                    if (pend[0] && pend[1]) begin
                        conflict <= 1'b1;
                        pend     <= rise;
                        busy     <= 1'b1;
                        if (RESET_PRIORITY) begin
                            st      <= PULSE_R;
                            R       <= 1'b1;
                            state_q <= 1'b0;
                        end else begin
                            st      <= PULSE_S;
                            S       <= 1'b1;
                            state_q <= 1'b1;
                        end
                    end else if (pend[0]) begin
                        pend    <= {pend[1] | rise[1], rise[0]};
                        st      <= PULSE_S;
                        S       <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= 1'b1;
                    end else if (pend[1]) begin
                        pend    <= {rise[1], pend[0] | rise[0]};
                        st      <= PULSE_R;
                        R       <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= 1'b0;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (int'(fcnt) == PULSE_WIDTH - 1) begin
                        S    <= 1'b0;
                        R    <= 1'b0;
                        fcnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            st   <= IDLE;
                            busy <= 1'b0;
                        end else begin
                            st <= GAP;
                        end
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (int'(fcnt) == GAP_CYCLES - 1) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                        fcnt <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: begin
                    st   <= IDLE;
                    S    <= 1'b0;
                    R    <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Directed bench for sr_input_conditioner: latency, conflict, glitch rejection,
// queued requests, async reset and a bouncing-input invariant run.
module tb_sr_input_conditioner;

    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst;
    logic set_raw;
    logic reset_raw;
    logic s, r, busy, conflict, state_q;
    logic s0, r0, busy0, conflict0, state_q0;

    int errors = 0;
    int checks = 0;
    int s_run = 0;
    int r_run = 0;
    logic last_type = 1'b0;

    always #5 clk = ~clk;

    sr_input_conditioner dut (
        .clk      (clk),
        .rst      (rst),
        .set_raw  (set_raw),
        .reset_raw(reset_raw),
        .S        (s),
        .R        (r),
        .busy     (busy),
        .conflict (conflict),
        .state_q  (state_q)
    );

    sr_input_conditioner #(.RESET_PRIORITY(1'b0)) dut_p0 (
        .clk      (clk),
        .rst      (rst),
        .set_raw  (set_raw),
        .reset_raw(reset_raw),
        .S        (s0),
        .R        (r0),
        .busy     (busy0),
        .conflict (conflict0),
        .state_q  (state_q0)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            s_run     = 0;
            r_run     = 0;
            last_type = 1'b0;
        end else begin
            chk("s_and_r", s & r, 1'b0);
            if (s) last_type = 1'b1;
            else if (r) last_type = 1'b0;
            chk("state_q_track", state_q, last_type);
            if (s) s_run++;
            else begin
                if (s_run != 0) chk_int("s_width", s_run, PW);
                s_run = 0;
            end
            if (r) r_run++;
            else begin
                if (r_run != 0) chk_int("r_width", r_run, PW);
                r_run = 0;
            end
        end
    end

    initial begin
        int n;
        logic sp;
        rst       = 1'b1;
        set_raw   = 1'b0;
        reset_raw = 1'b0;
        tick(3);
        chk("rst_s", s, 1'b0);
        chk("rst_r", r, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_conflict", conflict, 1'b0);
        chk("rst_state_q", state_q, 1'b0);
        rst = 1'b0;
        tick(5);

        // 1: single set request, latency 8 edges
        set_raw = 1'b1;
        tick(7);
        chk("t1_s_early", s, 1'b0);
        chk("t1_busy_early", busy, 1'b0);
        tick(1);
        chk("t1_s_c8", s, 1'b1);
        chk("t1_busy_c8", busy, 1'b1);
        chk("t1_state_q_c8", state_q, 1'b1);
        chk("t1_r_c8", r, 1'b0);
        tick(1);
        chk("t1_s_c9", s, 1'b1);
        tick(1);
        chk("t1_s_c10", s, 1'b0);
        chk("t1_busy_c10", busy, 1'b1);
        tick(1);
        chk("t1_busy_c11", busy, 1'b0);
        set_raw = 1'b0;
        tick(12);

        // 2: simultaneous requests
        set_raw   = 1'b1;
        reset_raw = 1'b1;
        tick(8);
        chk("t2_r_c8", r, 1'b1);
        chk("t2_s_c8", s, 1'b0);
        chk("t2_conflict_c8", conflict, 1'b1);
        chk("t2_state_q", state_q, 1'b0);
        chk("t2p0_s_c8", s0, 1'b1);
        chk("t2p0_r_c8", r0, 1'b0);
        chk("t2p0_conflict_c8", conflict0, 1'b1);
        chk("t2p0_state_q", state_q0, 1'b1);
        tick(1);
        chk("t2_conflict_c9", conflict, 1'b0);
        chk("t2_r_c9", r, 1'b1);
        chk("t2_s_c9", s, 1'b0);
        chk("t2p0_conflict_c9", conflict0, 1'b0);
        chk("t2p0_s_c9", s0, 1'b1);
        tick(1);
        chk("t2_r_c10", r, 1'b0);
        chk("t2p0_s_c10", s0, 1'b0);
        tick(1);
        chk("t2_busy_c11", busy, 1'b0);
        set_raw   = 1'b0;
        reset_raw = 1'b0;
        tick(12);
        chk("t2_no_followup", busy, 1'b0);

        // 3: short glitch rejected, longer pulse accepted once
        set_raw = 1'b1;
        tick(3);
        set_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            chk("t3_glitch_busy", busy, 1'b0);
            chk("t3_glitch_s", s, 1'b0);
            chk("t3_glitch_lvl", dut.lvl[0], 1'b0);
        end
        set_raw = 1'b1;
        tick(6);
        set_raw = 1'b0;
        n  = 0;
        sp = s;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (s && !sp) n++;
            sp = s;
        end
        chk_int("t3_pulse_count", n, 1);
        tick(5);

        // 4: reset request arriving mid set pulse is queued
        set_raw = 1'b1;
        tick(8);
        chk("t4_s_c8", s, 1'b1);
        reset_raw = 1'b1;
        tick(1);
        chk("t4_s_c9", s, 1'b1);
        chk("t4_r_c9", r, 1'b0);
        tick(1);
        chk("t4_s_c10", s, 1'b0);
        chk("t4_r_c10", r, 1'b0);
        chk("t4_busy_c10", busy, 1'b1);
        tick(1);
        chk("t4_busy_c11", busy, 1'b0);
        tick(4);
        chk("t4_r_c15", r, 1'b0);
        tick(1);
        chk("t4_r_c16", r, 1'b1);
        chk("t4_state_q_c16", state_q, 1'b0);
        tick(1);
        chk("t4_r_c17", r, 1'b1);
        tick(1);
        chk("t4_r_c18", r, 1'b0);
        set_raw   = 1'b0;
        reset_raw = 1'b0;
        tick(15);

        // 5: async reset during a pulse
        reset_raw = 1'b1;
        tick(8);
        chk("t5_r_c8", r, 1'b1);
        #2;
        rst       = 1'b1;
        reset_raw = 1'b0;
        #1;
        chk("t5_r_async", r, 1'b0);
        chk("t5_busy_async", busy, 1'b0);
        chk("t5_state_q_async", state_q, 1'b0);
        chk("t5_pend_r", dut.pend[1], 1'b0);
        chk("t5_lvl_r", dut.lvl[1], 1'b0);
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("t5_quiet_r", r, 1'b0);
            chk("t5_quiet_busy", busy, 1'b0);
        end
        reset_raw = 1'b1;
        tick(7);
        chk("t5_new_r_early", r, 1'b0);
        tick(1);
        chk("t5_new_r", r, 1'b1);
        tick(2);
        reset_raw = 1'b0;
        tick(15);

        // 6: bouncing inputs, invariants checked by the negedge monitor
        n  = 0;
        sp = s | r;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7) == 0) set_raw = ~set_raw;
            if ($urandom_range(7) == 0) reset_raw = ~reset_raw;
            tick(1);
            if ((s | r) && !sp) n++;
            sp = s | r;
        end
        set_raw   = 1'b0;
        reset_raw = 1'b0;
        tick(40);
        chk("t6_idle_end", busy, 1'b0);
        chk("t6_some_pulses", n > 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
